// File: rtl/hazard_control_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_if
//
// Bundles every non-clock/reset signal of hazard_control_unit.
//   master modport : environment side (drives pipeline status, reads enables)
//   slave  modport : hazard_control_unit side
//
// Signal summary (direction seen from the slave):
//   in  is_valid_inst, is_rs_sel[NUM_RS], is_branch, rs_full[NUM_RS],
//       rob_full, br_resolve, br_exec_stall, ex_take_branch, commit_wr_mem,
//       lb_read_req, wb_valid[NUM_WB], wb_written[NUM_WB]
//   out if_enable, if_is_enable, if_is_flush, rob_enable, rs_enable[NUM_RS],
//       wb_enable[NUM_WB], lb_mem_grant, br_in_flight[BRW], fetch_priority
//
// Handshake semantics: all inputs are level signals sampled on every rising
// clock edge; enables are combinational and are valid for the same cycle.
//
// Optional macro HAZARD_STATS_EN adds the 32-bit stall statistics outputs
// stat_rob_stall, stat_rs_stall, stat_br_stall, stat_mem_stall.
// ---------------------------------------------------------------------------
interface hazard_control_unit_if #(
    parameter int NUM_RS = 2,
    parameter int NUM_WB = 3,
    parameter int BRW    = 1
);
    logic              is_valid_inst;
    logic [NUM_RS-1:0] is_rs_sel;
    logic              is_branch;
    logic [NUM_RS-1:0] rs_full;
    logic              rob_full;
    logic              br_resolve;
    logic              br_exec_stall;
    logic              ex_take_branch;
    logic              commit_wr_mem;
    logic              lb_read_req;
    logic [NUM_WB-1:0] wb_valid;
    logic [NUM_WB-1:0] wb_written;

    logic              if_enable;
    logic              if_is_enable;
    logic              if_is_flush;
    logic              rob_enable;
    logic [NUM_RS-1:0] rs_enable;
    logic [NUM_WB-1:0] wb_enable;
    logic              lb_mem_grant;
    logic [BRW-1:0]    br_in_flight;
    logic              fetch_priority;

`ifdef HAZARD_STATS_EN
    logic [31:0]       stat_rob_stall;
    logic [31:0]       stat_rs_stall;
    logic [31:0]       stat_br_stall;
    logic [31:0]       stat_mem_stall;
`endif

    modport master (
        output is_valid_inst, is_rs_sel, is_branch, rs_full, rob_full,
               br_resolve, br_exec_stall, ex_take_branch, commit_wr_mem,
               lb_read_req, wb_valid, wb_written,
        input  if_enable, if_is_enable, if_is_flush, rob_enable, rs_enable,
               wb_enable, lb_mem_grant, br_in_flight, fetch_priority
`ifdef HAZARD_STATS_EN
        , input stat_rob_stall, stat_rs_stall, stat_br_stall, stat_mem_stall
`endif
    );

    modport slave (
        input  is_valid_inst, is_rs_sel, is_branch, rs_full, rob_full,
               br_resolve, br_exec_stall, ex_take_branch, commit_wr_mem,
               lb_read_req, wb_valid, wb_written,
        output if_enable, if_is_enable, if_is_flush, rob_enable, rs_enable,
               wb_enable, lb_mem_grant, br_in_flight, fetch_priority
`ifdef HAZARD_STATS_EN
        , output stat_rob_stall, stat_rs_stall, stat_br_stall, stat_mem_stall
`endif
    );
endinterface

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Stall / flush / enable generation for a multi-class reservation-station
// pipeline. Tracks up to MAX_BR unresolved branches and arbitrates the shared
// memory port between the load buffer and instruction fetch, with a
// starvation guard that hands fetch the port for one cycle after
// STARVE_LIMIT consecutive blocked cycles (STARVE_LIMIT = 0 disables it).
//
// Ports:
//   clock   : system clock (rising edge)
//   reset_n : asynchronous active-low reset
//   bus     : hazard_control_unit_if.slave (see interface header)
//
// Debug visibility: the branch counter is br_in_flight and the arbiter state
// is fetch_priority, both on the bus.
//
// Optional macro HAZARD_STATS_EN: saturating 32-bit counters of cycles in
// which each stall cause was active while an instruction was waiting in IS.
// ---------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int NUM_RS       = 2,
    parameter int NUM_WB       = 3,
    parameter int MAX_BR       = 1,
    parameter int STARVE_LIMIT = 4,
    localparam int BRW         = $clog2(MAX_BR + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    hazard_control_unit_if.slave bus
);
    logic           rs_sel_full;
    logic           br_stall;
    logic           is_stall;
    logic           is_enable;
    logic           lb_grant;
    logic           mem_hazard;
    logic           br_inc;
    logic           br_dec;
    logic [BRW-1:0] br_cnt_q;
    logic [BRW-1:0] br_cnt_d;
    logic           fetch_priority_q;

    // ---------------- combinational enables ----------------
    assign rs_sel_full = |(bus.is_rs_sel & bus.rs_full);
    assign br_stall    = (br_cnt_q == BRW'(MAX_BR));
    assign is_stall    = bus.rob_full | rs_sel_full | br_stall;
    assign is_enable   = bus.is_valid_inst & ~is_stall & ~bus.ex_take_branch;

    // Store commit always owns the port; otherwise the load buffer gets it
    // unless this is the one cycle reserved for fetch.
    assign lb_grant    = bus.lb_read_req & ~bus.commit_wr_mem & ~fetch_priority_q;
    assign mem_hazard  = bus.commit_wr_mem | lb_grant;

    assign bus.rob_enable     = is_enable;
    assign bus.rs_enable      = bus.is_rs_sel & {NUM_RS{is_enable}};
    assign bus.lb_mem_grant   = lb_grant;
    assign bus.if_enable      = ~mem_hazard & ~is_stall;
    assign bus.if_is_enable   = ~is_stall;
    // When fetch loses the port but IS is advancing, the IF/IS register must
    // take a bubble rather than re-present the consumed instruction.
    assign bus.if_is_flush    = bus.ex_take_branch | (mem_hazard & ~is_stall);
    assign bus.wb_enable      = ~bus.wb_valid | bus.wb_written;
    assign bus.br_in_flight   = br_cnt_q;
    assign bus.fetch_priority = fetch_priority_q;

    // ---------------- unresolved-branch counter ----------------
    assign br_inc = is_enable & bus.is_branch;
    assign br_dec = bus.br_resolve & ~bus.br_exec_stall;

    always_comb begin
        br_cnt_d = br_cnt_q;
        if (bus.ex_take_branch) begin
            br_cnt_d = '0;                       // younger branches squashed
        end else if (br_inc && !br_dec) begin
            br_cnt_d = br_cnt_q + BRW'(1);       // br_stall prevents overflow
        end else if (br_dec && !br_inc && (br_cnt_q != '0)) begin
            br_cnt_d = br_cnt_q - BRW'(1);       // floor at zero
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            br_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
        end
    end

    // ---------------- fetch starvation arbiter ----------------
    generate
        if (STARVE_LIMIT > 0) begin : g_arb
            localparam int SCW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
            logic [SCW-1:0] starve_cnt_q;
            logic [SCW-1:0] starve_cnt_d;
            logic           fetch_priority_d;
            logic           blocked;

            // Fetch is only "starved" when it would otherwise have advanced.
            assign blocked = lb_grant & ~is_stall;

            // The priority cycle itself has lb_grant low, so blocked is low
            // and priority drops again after exactly one cycle.
            always_comb begin
                starve_cnt_d     = '0;
                fetch_priority_d = 1'b0;
                if (!bus.ex_take_branch && blocked) begin
                    if (starve_cnt_q == SCW'(STARVE_LIMIT - 1)) begin
                        fetch_priority_d = 1'b1;
                    end else begin
                        starve_cnt_d = starve_cnt_q + SCW'(1);
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    starve_cnt_q     <= '0;
                    fetch_priority_q <= 1'b0;
                end else begin
                    starve_cnt_q     <= starve_cnt_d;
                    fetch_priority_q <= fetch_priority_d;
                end
            end
        end else begin : g_no_arb
            assign fetch_priority_q = 1'b0;
        end
    endgenerate

`ifdef HAZARD_STATS_EN
    // ---------------- stall statistics ----------------
    logic [31:0] stat_rob_q;
    logic [31:0] stat_rs_q;
    logic [31:0] stat_br_q;
    logic [31:0] stat_mem_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_rob_q <= '0;
            stat_rs_q  <= '0;
            stat_br_q  <= '0;
            stat_mem_q <= '0;
        end else if (bus.is_valid_inst) begin
            if (bus.rob_full && (stat_rob_q != '1)) stat_rob_q <= stat_rob_q + 32'd1;
            if (rs_sel_full  && (stat_rs_q  != '1)) stat_rs_q  <= stat_rs_q  + 32'd1;
            if (br_stall     && (stat_br_q  != '1)) stat_br_q  <= stat_br_q  + 32'd1;
            if (mem_hazard   && (stat_mem_q != '1)) stat_mem_q <= stat_mem_q + 32'd1;
        end
    end

    assign bus.stat_rob_stall = stat_rob_q;
    assign bus.stat_rs_stall  = stat_rs_q;
    assign bus.stat_br_stall  = stat_br_q;
    assign bus.stat_mem_stall = stat_mem_q;
`endif
endmodule
